// File: rtl/mul_div_unit.sv
// mul_div_unit: multi-cycle multiply/divide unit beside the EX-stage ALU.
// Holds the HI/LO architectural registers. A mult/div result is computed
// when the operation is accepted, parked in pending registers, and committed
// to HI/LO once the busy window has elapsed.
module mul_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic        we_hilo,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    state_e           state_r;
    logic             busy_r;
    logic [CNT_W-1:0] cnt_r;
    logic [31:0]      hi_r;
    logic [31:0]      lo_r;
    logic [31:0]      pend_hi_r;
    logic [31:0]      pend_lo_r;
    logic             pend_wr_r;

    // Multiply datapath: operands widened to 64 bits so the low 64 product bits are exact.
    logic [63:0] a_sx_s, b_sx_s, a_zx_s, b_zx_s;
    logic [63:0] smul_s, umul_s;

    assign a_sx_s = {{32{A[31]}}, A};
    assign b_sx_s = {{32{B[31]}}, B};
    assign a_zx_s = {32'd0, A};
    assign b_zx_s = {32'd0, B};
    assign smul_s = a_sx_s * b_sx_s;
    assign umul_s = a_zx_s * b_zx_s;

    // Divide datapath: one unsigned divider shared by div and divu. Signed
    // division runs on magnitudes and re-applies signs afterwards, which gives
    // truncation toward zero and 0x80000000 / -1 = 0x80000000 rem 0 naturally.
    logic        op_signed_s;
    logic        a_neg_s, b_neg_s;
    logic [31:0] a_mag_s, b_mag_s;
    logic [31:0] dividend_s, divisor_s, divisor_safe_s;
    logic        div_zero_s;
    logic [31:0] uq_s, ur_s;
    logic [31:0] q_s, r_s;

    assign op_signed_s    = (md_op == OP_DIV);
    assign a_neg_s        = op_signed_s & A[31];
    assign b_neg_s        = op_signed_s & B[31];
    assign a_mag_s        = a_neg_s ? (32'd0 - A) : A;
    assign b_mag_s        = b_neg_s ? (32'd0 - B) : B;
    assign dividend_s     = a_mag_s;
    assign divisor_s      = b_mag_s;
    assign div_zero_s     = (B == 32'd0);
    assign divisor_safe_s = div_zero_s ? 32'd1 : divisor_s;
    assign uq_s           = dividend_s / divisor_safe_s;
    assign ur_s           = dividend_s % divisor_safe_s;
    assign q_s            = (a_neg_s ^ b_neg_s) ? (32'd0 - uq_s) : uq_s;
    assign r_s            = a_neg_s ? (32'd0 - ur_s) : ur_s;

    logic             launch_s;
    logic             res_wr_s;
    logic [CNT_W-1:0] load_s;
    logic [31:0]      res_hi_s;
    logic [31:0]      res_lo_s;

    // Select the result, commit enable and busy length for the requested operation.
    always_comb begin
        launch_s = 1'b0;
        res_wr_s = 1'b0;
        load_s   = '0;
        res_hi_s = 32'd0;
        res_lo_s = 32'd0;
        case (md_op)
            OP_MULT: begin
                launch_s = 1'b1;
                res_wr_s = 1'b1;
                load_s   = MULT_LOAD;
                res_hi_s = smul_s[63:32];
                res_lo_s = smul_s[31:0];
            end
            OP_MULTU: begin
                launch_s = 1'b1;
                res_wr_s = 1'b1;
                load_s   = MULT_LOAD;
                res_hi_s = umul_s[63:32];
                res_lo_s = umul_s[31:0];
            end
            OP_DIV, OP_DIVU: begin
                // Divide by zero still occupies the unit but leaves HI/LO alone.
                launch_s = 1'b1;
                res_wr_s = ~div_zero_s;
                load_s   = DIV_LOAD;
                res_hi_s = r_s;
                res_lo_s = q_s;
            end
            default: begin
                launch_s = 1'b0;
                res_wr_s = 1'b0;
            end
        endcase
    end

    // Control FSM, busy counter, pending result and HI/LO architectural state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r   <= ST_IDLE;
            busy_r    <= 1'b0;
            cnt_r     <= '0;
            hi_r      <= 32'd0;
            lo_r      <= 32'd0;
            pend_hi_r <= 32'd0;
            pend_lo_r <= 32'd0;
            pend_wr_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        // start has priority over we_hilo; non-mul/div codes are no-ops.
                        if (launch_s) begin
                            pend_hi_r <= res_hi_s;
                            pend_lo_r <= res_lo_s;
                            pend_wr_r <= res_wr_s;
                            cnt_r     <= load_s;
                            busy_r    <= 1'b1;
                            state_r   <= ST_BUSY;
                        end
                    end else if (we_hilo) begin
                        if (md_op == OP_MTHI) begin
                            hi_r <= A;
                        end else if (md_op == OP_MTLO) begin
                            lo_r <= A;
                        end
                    end
                end
                ST_BUSY: begin
                    // New requests are ignored here; only the counter advances.
                    if (cnt_r <= CNT_ONE) begin
                        if (pend_wr_r) begin
                            hi_r <= pend_hi_r;
                            lo_r <= pend_lo_r;
                        end
                        cnt_r   <= '0;
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    cnt_r   <= '0;
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign HI   = hi_r;
    assign LO   = lo_r;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed vectors for mul_div_unit with hand-computed results.
module tb_mul_div_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic        we_hilo;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_hi = 32'd0;
    logic [31:0] exp_lo = 32'd0;

    mul_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .md_op   (md_op),
        .we_hilo (we_hilo),
        .A       (A),
        .B       (B),
        .busy    (busy),
        .HI      (HI),
        .LO      (LO)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    // Launch a mul/div at a falling edge, follow it through n busy cycles,
    // optionally poke a start/mthi into the busy window, then check the commit.
    task automatic run_op(input string tag, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b, input int n,
                          input logic [31:0] new_hi, input logic [31:0] new_lo,
                          input int inj_start, input int inj_we);
        @(negedge clk);
        start = 1'b1; md_op = op; A = a; B = b;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            start = 1'b0; we_hilo = 1'b0;
            chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
            chk({tag, "_hi_hold"}, HI, exp_hi);
            chk({tag, "_lo_hold"}, LO, exp_lo);
            if (i == inj_start) begin
                start = 1'b1; md_op = 3'd0; A = 32'd2; B = 32'd2;
            end
            if (i == inj_we) begin
                we_hilo = 1'b1; md_op = 3'd4; A = 32'hBAD0BAD0;
            end
        end
        @(negedge clk);
        start = 1'b0; we_hilo = 1'b0;
        exp_hi = new_hi;
        exp_lo = new_lo;
        chk({tag, "_done_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_hi"}, HI, exp_hi);
        chk({tag, "_lo"}, LO, exp_lo);
    endtask

    // Single-cycle move-to request (or no-op code) while idle.
    task automatic do_move(input string tag, input logic [2:0] op, input logic [31:0] a);
        @(negedge clk);
        we_hilo = 1'b1; md_op = op; A = a;
        @(negedge clk);
        we_hilo = 1'b0;
        if (op == 3'd4) exp_hi = a;
        if (op == 3'd5) exp_lo = a;
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_hi"}, HI, exp_hi);
        chk({tag, "_lo"}, LO, exp_lo);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; md_op = 3'd7; we_hilo = 1'b0;
        A = 32'd0; B = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_hi", HI, 32'd0);
        chk("rst_lo", LO, 32'd0);
        reset = 1'b1;

        // mult -2 * 3 = -6
        run_op("mult", 3'd0, 32'hFFFFFFFE, 32'd3, 5, 32'hFFFFFFFF, 32'hFFFFFFFA, 0, 0);
        // div -7 / 2 = -3 rem -1
        run_op("div", 3'd2, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD, 0, 0);
        // divu 0xFFFFFFF9 / 2 = 0x7FFFFFFC rem 1
        run_op("divu", 3'd3, 32'hFFFFFFF9, 32'd2, 10, 32'h00000001, 32'h7FFFFFFC, 0, 0);
        // signed overflow
        run_op("div_ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000, 0, 0);

        do_move("mthi", 3'd4, 32'h00001234);
        do_move("mtlo", 3'd5, 32'h00005678);
        // divide by zero leaves HI/LO untouched
        run_op("div0", 3'd2, 32'd77, 32'd0, 10, 32'h00001234, 32'h00005678, 0, 0);
        run_op("divu0", 3'd3, 32'd77, 32'd0, 10, 32'h00001234, 32'h00005678, 0, 0);

        run_op("multu", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, 32'hFFFFFFFE, 32'h00000001, 0, 0);
        do_move("mtlo2", 3'd5, 32'hDEADBEEF);
        do_move("nop6", 3'd6, 32'h55555555);

        // start with a no-op code stays idle
        @(negedge clk);
        start = 1'b1; md_op = 3'd7; A = 32'd9; B = 32'd9;
        @(negedge clk);
        start = 1'b0;
        chk("start_nop_busy", {31'd0, busy}, 32'd0);
        chk("start_nop_lo", LO, exp_lo);

        // 100 / 7 = 14 rem 2; stray mult in cycle 3 and mthi in cycle 5 ignored
        run_op("div_inj", 3'd2, 32'd100, 32'd7, 10, 32'd2, 32'd14, 3, 5);
        // one more idle cycle: the stray mult must not have started
        @(negedge clk);
        chk("inj_after_busy", {31'd0, busy}, 32'd0);
        chk("inj_after_lo", LO, 32'd14);

        // reset in busy cycle 4 of a mult aborts it
        @(negedge clk);
        start = 1'b1; md_op = 3'd0; A = 32'd5; B = 32'd5;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            start = 1'b0;
            chk("rmid_busy", {31'd0, busy}, 32'd1);
        end
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("rmid_busy0", {31'd0, busy}, 32'd0);
        chk("rmid_hi", HI, 32'd0);
        chk("rmid_lo", LO, 32'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("rmid_late_busy", {31'd0, busy}, 32'd0);
            chk("rmid_late_hi", HI, 32'd0);
            chk("rmid_late_lo", LO, 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
